wb_write_arbiter: RTL and testbench

//  Write-back arbiter feeding the register file's single write port (writeBackEn/Dest_wb/Result_WB).

---
 rtl/wb_write_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_wb_write_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_write_arbiter.sv
// -----------------------------------------------------------------------------
// wb_write_arbiter
//   Write-back arbiter for the register file's single write port. The in-order
//   WB-stage result always wins the port. Results from multi-cycle units
//   (multiplier, late loads) wait in a small FIFO and drain on cycles where
//   the WB stage is not writing. A pending-register mask marks the destinations
//   of queued writes so hazard detection can stall their readers.
//
//   A WB-stage write is younger than any queued or incoming multi-cycle write
//   to the same register. The older queued entry therefore stays in the FIFO
//   but is marked dead. It pops later with writeBackEn=0. Register 15 (PC) is
//   not part of the file, so writes to it never assert writeBackEn.
//
// Configuration macro:
//   MC_BYPASS_EN - when the FIFO is empty and the WB stage is idle, a
//                  multi-cycle result bypasses the queue and goes straight to
//                  the output registers.
//
// Ports:
//   clk          in   clock, all state on posedge
//   rst          in   asynchronous reset, active-low
//   pipe_wb_en   in   WB-stage write request (never stalled)
//   pipe_dest    in   WB-stage destination register
//   pipe_result  in   WB-stage write data
//   mc_valid     in   multi-cycle result valid
//   mc_dest      in   multi-cycle destination register
//   mc_result    in   multi-cycle write data
//   mc_ready     out  queue can accept (transfer on mc_valid && mc_ready)
//   writeBackEn  out  register-file write enable (registered)
//   Dest_wb      out  register-file write index (registered)
//   Result_WB    out  register-file write data (registered)
//   pending      out  bit r set = a live queued write targets register r
// -----------------------------------------------------------------------------
module wb_write_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pipe_wb_en,
  input  logic [ADDR_W-1:0] pipe_dest,
  input  logic [DATA_W-1:0] pipe_result,
  input  logic              mc_valid,
  input  logic [ADDR_W-1:0] mc_dest,
  input  logic [DATA_W-1:0] mc_result,
  output logic              mc_ready,
  output logic              writeBackEn,
  output logic [ADDR_W-1:0] Dest_wb,
  output logic [DATA_W-1:0] Result_WB,
  output logic [14:0]       pending
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [ADDR_W-1:0] PC_REG = ADDR_W'(15);

  // Queue control state (reset) and payload storage (not reset).
  logic [FIFO_DEPTH-1:0] live_q, live_d;
  logic [PW-1:0]         wptr_q, wptr_d;
  logic [PW-1:0]         rptr_q, rptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [ADDR_W-1:0]     dest_mem [FIFO_DEPTH];
  logic [DATA_W-1:0]     data_mem [FIFO_DEPTH];

  // Output registers.
  logic                  we_q, we_d;
  logic [ADDR_W-1:0]     dest_q, dest_d;
  logic [DATA_W-1:0]     res_q, res_d;

  logic fifo_full;
  logic fifo_empty;
  logic do_pop;
  logic do_push;
  logic do_bypass;
  logic push_live;

  assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);

  // Ready comes from the registered count only, so a full queue never
  // accepts even in a cycle that also pops.
  assign mc_ready = rst && !fifo_full;

  assign do_pop = !pipe_wb_en && !fifo_empty;

`ifdef MC_BYPASS_EN
  assign do_bypass = !pipe_wb_en && fifo_empty && mc_valid && (mc_dest != PC_REG);
`else
  assign do_bypass = 1'b0;
`endif

  assign do_push = mc_valid && mc_ready && !do_bypass;

  // An incoming result is dead on arrival if it targets the PC or if a
  // younger WB-stage write to the same register happens this cycle.
  assign push_live = (mc_dest != PC_REG) && !(pipe_wb_en && (pipe_dest == mc_dest));

  always_comb begin
    live_d  = live_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q + CW'(do_push) - CW'(do_pop);

    // A WB-stage write supersedes every queued write to the same register.
    if (pipe_wb_en) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        if (dest_mem[i] == pipe_dest) live_d[i] = 1'b0;
      end
    end

    // Popped slots are cleared so that live bits only cover occupied slots.
    if (do_pop) begin
      live_d[rptr_q] = 1'b0;
      rptr_d         = rptr_q + 1'b1;
    end

    if (do_push) begin
      live_d[wptr_q] = push_live;
      wptr_d         = wptr_q + 1'b1;
    end
  end

  always_comb begin
    we_d   = 1'b0;
    dest_d = dest_q;
    res_d  = res_q;
    if (pipe_wb_en) begin
      we_d   = (pipe_dest != PC_REG);
      dest_d = pipe_dest;
      res_d  = pipe_result;
    end else if (do_pop) begin
      we_d   = live_q[rptr_q];
      dest_d = dest_mem[rptr_q];
      res_d  = data_mem[rptr_q];
    end else if (do_bypass) begin
      we_d   = 1'b1;
      dest_d = mc_dest;
      res_d  = mc_result;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      live_q  <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      we_q    <= 1'b0;
      dest_q  <= '0;
      res_q   <= '0;
    end else begin
      live_q  <= live_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      we_q    <= we_d;
      dest_q  <= dest_d;
      res_q   <= res_d;
    end
  end

  // Payload storage is qualified by live_q, so it does not need a reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      dest_mem[wptr_q] <= mc_dest;
      data_mem[wptr_q] <= mc_result;
    end
  end

  always_comb begin
    pending = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      for (int r = 0; r < 15; r++) begin
        if (live_q[i] && (dest_mem[i] == ADDR_W'(r))) pending[r] = 1'b1;
      end
    end
  end

  assign writeBackEn = we_q;
  assign Dest_wb     = dest_q;
  assign Result_WB   = res_q;

endmodule

// File: tb/tb_wb_write_arbiter.sv
module tb_wb_write_arbiter;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int D  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          pipe_wb_en;
  logic [AW-1:0] pipe_dest;
  logic [DW-1:0] pipe_result;
  logic          mc_valid;
  logic [AW-1:0] mc_dest;
  logic [DW-1:0] mc_result;
  logic          mc_ready;
  logic          writeBackEn;
  logic [AW-1:0] Dest_wb;
  logic [DW-1:0] Result_WB;
  logic [14:0]   pending;

  wb_write_arbiter #(.DATA_W(DW), .ADDR_W(AW), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst),
    .pipe_wb_en(pipe_wb_en), .pipe_dest(pipe_dest), .pipe_result(pipe_result),
    .mc_valid(mc_valid), .mc_dest(mc_dest), .mc_result(mc_result),
    .mc_ready(mc_ready), .writeBackEn(writeBackEn), .Dest_wb(Dest_wb),
    .Result_WB(Result_WB), .pending(pending)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: queue of multi-cycle results still waiting, and the
  // list of register-file writes expected, tagged with the edge number.
  typedef struct {bit live; logic [3:0] dest; logic [31:0] data;} ent_t;
  typedef struct {int en; logic [3:0] dest; logic [31:0] data;} wr_t;
  ent_t mq[$];
  wr_t  exq[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (edge %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [14:0] model_pending();
    logic [14:0] p = '0;
    foreach (mq[i]) if (mq[i].live && mq[i].dest != 4'd15) p[int'(mq[i].dest)] = 1'b1;
    return p;
  endfunction

  // Monitor: every edge either produces the next expected write or no write.
  always @(negedge clk) begin
    if (exq.size() > 0 && exq[0].en == cyc) begin
      wr_t w;
      w = exq.pop_front();
      check("wr_en", 64'(writeBackEn), 64'(1));
      check("wr_dest", 64'(Dest_wb), 64'(w.dest));
      check("wr_data", 64'(Result_WB), 64'(w.data));
    end else begin
      check("idle_we", 64'(writeBackEn), 64'(0));
    end
  end

  // One clock of stimulus; compares ready/pending, then advances the model
  // for the coming edge.
  task automatic step(input bit pe, input logic [3:0] pd, input logic [31:0] pr,
                      input bit mv, input logic [3:0] md, input logic [31:0] mr,
                      output bit acc);
    bit mready;
    bit byp;
    ent_t e;
    @(negedge clk);
    #1;
    mready = (mq.size() < D);
    check("mc_ready", 64'(mc_ready), 64'(mready));
    check("pending", 64'(pending), 64'(model_pending()));
    pipe_wb_en = pe; pipe_dest = pd; pipe_result = pr;
    mc_valid = mv; mc_dest = md; mc_result = mr;
    byp = 1'b0;
    if (pe) begin
      if (pd != 4'd15) exq.push_back('{cyc + 1, pd, pr});
      foreach (mq[i]) if (mq[i].dest == pd) mq[i].live = 1'b0;
    end else if (mq.size() > 0) begin
      e = mq.pop_front();
      if (e.live) exq.push_back('{cyc + 1, e.dest, e.data});
    end
`ifdef MC_BYPASS_EN
    else if (mv && md != 4'd15) begin
      byp = 1'b1;
      exq.push_back('{cyc + 1, md, mr});
    end
`endif
    acc = mv && mready;
    if (acc && !byp) mq.push_back('{(md != 4'd15) && !(pe && pd == md), md, mr});
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) step(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, a);
  endtask

  task automatic check_reset_outputs();
    check("rst_we", 64'(writeBackEn), 64'(0));
    check("rst_dest", 64'(Dest_wb), 64'(0));
    check("rst_result", 64'(Result_WB), 64'(0));
    check("rst_mc_ready", 64'(mc_ready), 64'(0));
    check("rst_pending", 64'(pending), 64'(0));
  endtask

  // Reset applied mid-operation: all queued work is discarded.
  task automatic apply_reset();
    @(negedge clk);
    #1;
    rst = 1'b0;
    mc_valid = 1'b1; mc_dest = 4'd6; mc_result = 32'h5555;
    pipe_wb_en = 1'b0;
    mq.delete();
    check("rst_exq_empty", 64'(exq.size()), 64'(0));
    @(negedge clk);
    #1;
    check_reset_outputs();
    rst = 1'b1;
    mc_valid = 1'b0;
  endtask

  initial begin
    bit a;
    int tries;
    rst = 1'b0;
    pipe_wb_en = 1'b0; pipe_dest = '0; pipe_result = '0;
    mc_valid = 1'b1; mc_dest = 4'd4; mc_result = 32'h1234;

    // T1: reset with a valid multi-cycle result present
    @(negedge clk);
    #1;
    check_reset_outputs();
    @(negedge clk);
    #1;
    check_reset_outputs();
    rst = 1'b1;
    mc_valid = 1'b0;

    // T2: WB-stage write only
    step(1'b1, 4'd3, 32'hDEADBEEF, 1'b0, 4'd0, 32'd0, a);
    idle(2);

    // T3: contention, WB-stage writes back-to-back while R5 waits
    step(1'b1, 4'd2, 32'h22, 1'b1, 4'd5, 32'h11, a);
    step(1'b1, 4'd2, 32'h23, 1'b0, 4'd0, 32'd0, a);
    step(1'b1, 4'd2, 32'h24, 1'b0, 4'd0, 32'd0, a);
    idle(3);

    // T4: kill of a queued write by a younger WB-stage write
    step(1'b1, 4'd1, 32'h01, 1'b1, 4'd7, 32'hAA, a);
    step(1'b1, 4'd7, 32'hBB, 1'b0, 4'd0, 32'd0, a);
    idle(3);

    // Same-cycle enqueue with equal destination, and PC destinations
    step(1'b1, 4'd9, 32'h99, 1'b1, 4'd9, 32'h98, a);
    step(1'b1, 4'd15, 32'hF0, 1'b1, 4'd15, 32'hF1, a);
    idle(3);

    // T5: fill the queue while the WB stage holds the port
    for (int i = 0; i < D; i++)
      step(1'b1, 4'd0, 32'h100 + i, 1'b1, 4'(8 + i), 32'h200 + i, a);
    step(1'b1, 4'd0, 32'h1FF, 1'b1, 4'd12, 32'h2FF, a);
    tries = 0;
    while (!a && tries < 20) begin
      step(1'b0, 4'd0, 32'd0, 1'b1, 4'd12, 32'h2FF, a);
      tries++;
    end
    check("fifth_accepted", 64'(a), 64'(1));
    idle(6);

    // T6: empty queue, single multi-cycle result (bypass depends on build)
    step(1'b0, 4'd0, 32'd0, 1'b1, 4'd9, 32'h42, a);
    idle(3);

    // Reset in the middle of queued work
    for (int i = 0; i < 3; i++)
      step(1'b1, 4'd1, 32'h300 + i, 1'b1, 4'(2 + i), 32'h400 + i, a);
    apply_reset();
    idle(3);

    // Randomized traffic on a small register set to provoke kills
    for (int i = 0; i < 600; i++) begin
      bit pe;
      bit mv;
      logic [3:0] pd;
      logic [3:0] md;
      pe = ($urandom_range(0, 2) == 0);
      mv = ($urandom_range(0, 1) == 1);
      pd = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 5));
      md = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 5));
      step(pe, pd, $urandom, mv, md, $urandom, a);
    end
    idle(10);

    check("exq_drained", 64'(exq.size()), 64'(0));
    check("model_drained", 64'(mq.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
